regfile_wb_arbiter: RTL
=======================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, data width of a register write.
REQ-002 The block SHALL have parameter REG_AW, default 5, register index width.
REQ-003 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port req0_valid_i  input  1  writeback request from source 0 (ALU).
REQ-006 The block SHALL have port req0_rd_i  input  REG_AW  destination register of source 0.
REQ-007 The block SHALL have port req0_data_i  input  XLEN  write data of source 0.
REQ-008 The block SHALL have port req0_ready_o  output  1  source 0 request accepted this cycle.
REQ-009 The block SHALL have ports req1_valid_i, req1_rd_i, req1_data_i, req1_ready_o, identical in width and meaning to REQ-005..008, for source 1 (load unit).
REQ-010 The block SHALL have port flush_i  input  1  discard any write not yet presented to the register file.
REQ-011 The block SHALL have port wr_port_o  output  REG_AW  register file write index.
REQ-012 The block SHALL have port wr_data_o  output  XLEN  register file write data.
REQ-013 The block SHALL have port ctrl_reg_we_o  output  1  register file write enable.
REQ-014 The block SHALL have port grant_o  output  2  one-hot record of the source accepted on the previous edge.

Function
REQ-015 A request SHALL be accepted on a rising edge where its valid and ready are both high.
REQ-016 At most one ready SHALL be high per cycle; ready SHALL depend only on both valids, flush_i and the priority state.
REQ-017 With one valid request and flush_i low, that source's ready SHALL be high in the same cycle.
REQ-018 With both valid, the source selected by the priority state SHALL receive ready; the other SHALL hold valid, rd and data stable until accepted.
REQ-019 An accepted request SHALL be registered into the output stage, so wr_port_o/wr_data_o/ctrl_reg_we_o reflect it during exactly the next cycle (latency 1).
REQ-020 A cycle with no acceptance SHALL leave ctrl_reg_we_o low in the next cycle; wr_port_o/wr_data_o hold their last values.
REQ-021 An accepted request with rd equal to 0 SHALL be acknowledged normally but produce ctrl_reg_we_o low; grant_o still records it.
REQ-022 flush_i high SHALL force both readys low and clear ctrl_reg_we_o and grant_o on the next edge.
REQ-023 Priority state SHALL be a 1-bit pointer: after a contended grant (both valid) it SHALL point to the loser; uncontended grants SHALL leave it unchanged.
REQ-024 Under continuous contention, neither source SHALL wait more than one cycle between grants.
REQ-025 Both sources targeting the same rd SHALL be serialised in grant order; no merging or dropping.

Reset
REQ-026 While rst is high on an edge: ctrl_reg_we_o=0, wr_port_o=0, wr_data_o=0, grant_o=2'b00, pointer=source 0.
REQ-027 While rst is high both readys SHALL be low; a request in flight at reset SHALL be discarded.

Configuration
REQ-028 Macro WBARB_RR_EN SHALL select round-robin arbitration per REQ-023/024 when defined.
REQ-029 Without WBARB_RR_EN, source 1 (load) SHALL always win contention, the pointer SHALL not exist, and REQ-024 SHALL not apply.

Structure
REQ-030 Package regfile_pkg SHALL hold XLEN/REG_AW defaults and the grant_o one-hot encoding constants (GRANT_NONE, GRANT_SRC0, GRANT_SRC1).
REQ-031 Arbitration SHALL be a sub-module rr_arbiter2 (two valids in, one-hot grant out, pointer state inside); the output stage stays in regfile_wb_arbiter.

Verification
REQ-032 Reset then idle: rst high 2 cycles -> all outputs 0, readys 0; after release, idle -> ctrl_reg_we_o stays 0.
REQ-033 Single source: req0 rd=5 data=0xDEADBEEF for one cycle -> req0_ready_o=1 same cycle; next cycle we=1, wr_port_o=5, wr_data_o=0xDEADBEEF, grant_o=GRANT_SRC0.
REQ-034 Contention, WBARB_RR_EN defined: both valid 4 cycles (rd 1 / rd 2) after reset -> grants src0, src1, src0, src1; writes rd1, rd2, rd1, rd2.
REQ-035 Contention, macro undefined: both valid 3 cycles -> src1 granted every cycle, req0_ready_o never high.
REQ-036 x0 write: req1 rd=0 data=0x1234 -> req1_ready_o=1; next cycle ctrl_reg_we_o=0, grant_o=GRANT_SRC1.
REQ-037 Flush: req0 accepted at edge N, flush_i high in cycle N+1 with req1 valid -> req1_ready_o=0; cycle N+2 ctrl_reg_we_o=0, grant_o=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback arbiter.
//   XLEN_DEF / REG_AW_DEF : default data and register index widths
//   GRANT_*               : one-hot encoding used on grant_o and internally
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_SRC0 = 2'b01;
    localparam logic [1:0] GRANT_SRC1 = 2'b10;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester arbiter for the writeback port.
// Macro WBARB_RR_EN: when defined, a 1-bit pointer alternates priority after
// each contended grant; when undefined, source 1 always wins and no state exists.
// Ports:
//   clk       : clock (only present with WBARB_RR_EN)
//   rst       : synchronous active-high reset, forces grant low
//   valid_i   : request valids, bit 0 = source 0, bit 1 = source 1
//   flush_i   : suppresses any grant this cycle
//   grant_o   : one-hot grant, combinational, doubles as the readys
module rr_arbiter2
    import regfile_pkg::*;
(
`ifdef WBARB_RR_EN
    input  logic       clk,
`endif
    input  logic       rst,
    input  logic [1:0] valid_i,
    input  logic       flush_i,
    output logic [1:0] grant_o
);

    logic contend;
    assign contend = valid_i[0] & valid_i[1];

`ifdef WBARB_RR_EN
    // ptr_q = 0 gives source 0 priority, 1 gives source 1 priority
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant_o = GRANT_NONE;
        ptr_d   = ptr_q;
        if (!rst && !flush_i) begin
            if (contend) begin
                grant_o = ptr_q ? GRANT_SRC1 : GRANT_SRC0;
                // point at the loser so it wins the next contended cycle
                ptr_d   = ~ptr_q;
            end else if (valid_i[0]) begin
                grant_o = GRANT_SRC0;
            end else if (valid_i[1]) begin
                grant_o = GRANT_SRC1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        grant_o = GRANT_NONE;
        if (!rst && !flush_i) begin
            if (valid_i[1]) begin
                grant_o = GRANT_SRC1;
            end else if (valid_i[0]) begin
                grant_o = GRANT_SRC0;
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: merges ALU (source 0) and load-unit (source 1) writes
// onto the single register-file write port with one cycle of latency.
// Macro WBARB_RR_EN selects round-robin contention handling (see rr_arbiter2).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   reqN_valid_i/rd_i/data_i  : writeback request of source N
//   reqN_ready_o              : request of source N accepted this cycle
//   flush_i                   : drop anything not yet on the write port
//   wr_port_o/wr_data_o       : register file write index / data
//   ctrl_reg_we_o             : register file write enable
//   grant_o                   : one-hot source accepted on the previous edge
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid_i,
    input  logic [REG_AW-1:0] req0_rd_i,
    input  logic [XLEN-1:0]   req0_data_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic [REG_AW-1:0] req1_rd_i,
    input  logic [XLEN-1:0]   req1_data_i,
    output logic              req1_ready_o,
    input  logic              flush_i,
    output logic [REG_AW-1:0] wr_port_o,
    output logic [XLEN-1:0]   wr_data_o,
    output logic              ctrl_reg_we_o,
    output logic [1:0]        grant_o
);

    logic [1:0]        grant;
    logic [REG_AW-1:0] port_q, port_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              we_q,   we_d;
    logic [1:0]        gnt_q,  gnt_d;

    rr_arbiter2 u_arb (
`ifdef WBARB_RR_EN
        .clk     (clk),
`endif
        .rst     (rst),
        .valid_i ({req1_valid_i, req0_valid_i}),
        .flush_i (flush_i),
        .grant_o (grant)
    );

    assign req0_ready_o = grant[0];
    assign req1_ready_o = grant[1];

    always_comb begin
        port_d = port_q;
        data_d = data_q;
        we_d   = 1'b0;
        gnt_d  = grant;
        if (grant == GRANT_SRC0) begin
            port_d = req0_rd_i;
            data_d = req0_data_i;
            we_d   = (req0_rd_i != '0);
        end else if (grant == GRANT_SRC1) begin
            port_d = req1_rd_i;
            data_d = req1_data_i;
            // x0 writes are acknowledged but never reach the register file
            we_d   = (req1_rd_i != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_q <= '0;
            data_q <= '0;
            we_q   <= 1'b0;
            gnt_q  <= GRANT_NONE;
        end else begin
            port_q <= port_d;
            data_q <= data_d;
            we_q   <= we_d;
            gnt_q  <= gnt_d;
        end
    end

    assign wr_port_o     = port_q;
    assign wr_data_o     = data_q;
    assign ctrl_reg_we_o = we_q;
    assign grant_o       = gnt_q;

endmodule
